conv_channel_accumulator: RTL

//  Downstream consumer of the 25-input carry-save adder tree (one 5x5 conv window per beat).

---
 rtl/conv_channel_accumulator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/conv_channel_accumulator.sv
// Channel accumulator behind the 5x5 carry-save adder tree.
// Sums N_CH per-channel window sums plus a signed bias into one pixel, then
// applies ReLU, a truncating right shift and unsigned saturation to W_OUT bits.
module conv_channel_accumulator #(
   parameter int W_IN  = 19,
   parameter int N_CH  = 8,
   parameter int W_ACC = 24,
   parameter int W_OUT = 8,
   parameter int W_SH  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [W_ACC-1:0] bias,
   input  logic [W_SH-1:0]  shift,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  in_sum,
   input  logic             in_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_OUT-1:0] out_data,
   output logic             out_sat,
   output logic             busy
);

   localparam int CNT_W = $clog2(N_CH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CH - 1);
   localparam logic [W_ACC-1:0] ACC_MAX  = {1'b0, {(W_ACC-1){1'b1}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      CALC  = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [W_ACC-1:0] acc;
   logic [CNT_W-1:0] ch_cnt;
   logic [W_SH-1:0]  shift_l;

   logic             beat;
   logic [W_ACC-1:0] x;
   logic [W_ACC-1:0] add_a;
   logic [W_ACC:0]   sum_ext;
   logic [W_ACC-1:0] sum_sat;
   logic [W_ACC-1:0] shifted;
   logic             too_big;
   logic [W_OUT-1:0] calc_data;
   logic             calc_sat;

   // Next-state logic; in_ready comes from the state alone so out_ready never reaches it.
   always_comb begin
      state_next = state;
      in_ready   = !rst && (state == IDLE || state == ACCUM);
      beat       = in_valid && in_ready;
      case (state)
         IDLE:    if (beat) state_next = (N_CH == 1) ? CALC : ACCUM;
         ACCUM:   if (beat && ch_cnt == LAST_CNT) state_next = CALC;
         CALC:    state_next = OUT;
         OUT:     if (out_valid && out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (clear) state_next = IDLE;
   end

   // Accumulate with positive clamp; the operand is non-negative so only upward overflow exists.
   always_comb begin
      x       = {{(W_ACC-W_IN-1){1'b0}}, in_cout, in_sum};
      add_a   = (state == IDLE) ? bias : acc;
      sum_ext = {add_a[W_ACC-1], add_a} + {1'b0, x};
      sum_sat = (sum_ext[W_ACC] != sum_ext[W_ACC-1]) ? ACC_MAX : sum_ext[W_ACC-1:0];
   end

   // ReLU, truncating shift (large shifts drain to zero) and clip to the output width.
   always_comb begin
      shifted   = acc >> shift_l;
      too_big   = |shifted[W_ACC-1:W_OUT];
      calc_data = shifted[W_OUT-1:0];
      calc_sat  = 1'b0;
      if (acc[W_ACC-1]) begin
         calc_data = '0;
      end else if (too_big) begin
         calc_data = '1;
         calc_sat  = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Datapath registers; clear wins over both handshakes and drops any beat in that cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         ch_cnt    <= '0;
         shift_l   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (clear) begin
         acc       <= '0;
         ch_cnt    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (beat) begin
                  acc     <= sum_sat;
                  shift_l <= shift;
                  ch_cnt  <= CNT_W'(1);
               end
            end
            ACCUM: begin
               if (beat) begin
                  acc    <= sum_sat;
                  ch_cnt <= ch_cnt + CNT_W'(1);
               end
            end
            CALC: begin
               out_data  <= calc_data;
               out_sat   <= calc_sat;
               out_valid <= 1'b1;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= '0;
                  ch_cnt    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule
